// File: rtl/mem_arb_pkg.sv
// Shared constants, types and helpers for the memory arbiter.
// Index-based helpers use the widest supported channel count and callers narrow the results.
package mem_arb_pkg;

  localparam int DEF_NUM_CH   = 3;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_HOLD = 16;
  localparam int MAX_CH       = 16;
  localparam int MAX_CH_W     = 4;

  typedef struct packed {
    logic                found;
    logic [MAX_CH_W-1:0] idx;
  } pick_t;

  function automatic logic [MAX_CH-1:0] to_onehot(input logic [MAX_CH_W-1:0] idx);
    logic [MAX_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First set bit of vec[0..n-1] at or after ptr, wrapping. Scanning from the far end
  // lets the nearest hit overwrite the others.
  function automatic pick_t rr_first(input logic [MAX_CH-1:0]   vec,
                                     input logic [MAX_CH_W-1:0] ptr,
                                     input int                  n);
    pick_t p;
    int    j;
    p = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (vec[MAX_CH_W'(j)]) begin
          p.found = 1'b1;
          p.idx   = MAX_CH_W'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/arb_index_fifo.sv
// Small index FIFO holding channel numbers in arrival order.
// Pointers wrap at DEPTH, which does not have to be a power of two.
module arb_index_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2,
  localparam int PW   = (DEPTH < 2) ? 1 : $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop_ok;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign dout   = mem[rd_ptr];
  assign pop_ok = pop && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop_ok) rd_ptr <= wrap_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// First-come N-channel arbiter with rotating tie-break, hold-limit preemption
// and the AND-OR mux that drives the shared memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req,
  output logic [NUM_CH-1:0]        grant,
  output logic                     preempted,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH-1:0]        ch_rw,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_rw
);

  // Handshake: req[i] is a level held for as long as channel i wants the port; grant[i]
  // high means the port is channel i's this cycle; dropping req releases it on the next edge.

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int HW    = $clog2(MAX_HOLD + 2);
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  logic [NUM_CH-1:0] busy;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   owner;
  logic [HW-1:0]     hold_cnt;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CH_W-1:0]   fifo_din;
  logic [CH_W-1:0]   fifo_dout;
  logic [CNT_W-1:0]  fifo_count;

  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] arr_onehot;
  pick_t             pick;
  logic              owned;
  logic              release_ev;
  logic              preempt_ev;
  logic              arrive_ev;

  arb_index_fifo #(
    .DEPTH (NUM_CH),
    .W     (CH_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Preemption owns the single push slot, so a coincident arrival waits a cycle.
  always_comb begin
    cand       = req & ~busy;
    pick       = rr_first(MAX_CH'(cand), MAX_CH_W'(rr_ptr), NUM_CH);
    arr_onehot = NUM_CH'(to_onehot(pick.idx));
    owned      = |grant;
    release_ev = owned && !req[owner];
    preempt_ev = (MAX_HOLD > 0) && owned && req[owner] &&
                 (hold_cnt >= HOLD_LAST) && !fifo_empty;
    arrive_ev  = pick.found && !preempt_ev;
    fifo_push  = preempt_ev || arrive_ev;
    fifo_din   = preempt_ev ? owner : CH_W'(pick.idx);
    fifo_pop   = !owned && !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant     <= '0;
      owner     <= '0;
      preempted <= 1'b0;
      busy      <= '0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
    end else begin
      preempted <= preempt_ev;
      if (arrive_ev) begin
        rr_ptr <= (int'(pick.idx) == NUM_CH - 1) ? '0 : CH_W'(pick.idx + 1'b1);
      end
      busy <= (busy | (arrive_ev ? arr_onehot : '0)) & ~(release_ev ? grant : '0);
      if (fifo_pop) begin
        grant    <= NUM_CH'(to_onehot(MAX_CH_W'(fifo_dout)));
        owner    <= fifo_dout;
        hold_cnt <= '0;
      end else if (release_ev || preempt_ev) begin
        grant <= '0;
      end else if (owned && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign mem_en = |grant;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rw    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        mem_addr  = mem_addr  | ch_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = mem_wdata | ch_wdata[i*DATA_W +: DATA_W];
        mem_rw    = mem_rw    | ch_rw[i];
      end
    end
  end

  // Each channel holds at most one FIFO entry, and every queued channel is busy.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(fifo_push && fifo_full));
      assert (32'(fifo_count) <= 32'($countones(busy)));
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (hold limit 4 and disabled) driven by the same
// directed and random stimulus, checked every cycle against a ticket-order model.
module tb_mem_arbiter;

  localparam int N    = 3;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int HOLD = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_wdata;
  logic [N-1:0]    ch_rw;

  logic [N-1:0]  grant0, grant1;
  logic          preempted0, preempted1, mem_en0, mem_en1, mem_rw0, mem_rw1;
  logic [AW-1:0] mem_addr0, mem_addr1;
  logic [DW-1:0] mem_wdata0, mem_wdata1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a queued channel carries a ticket; the smallest ticket is the FIFO head.
  int ticket [2][N];
  bit mbusy  [2][N];
  int rr     [2];
  int owner  [2];
  int hold   [2];
  int seq    [2];
  bit exp_pre[2];

  logic [N-1:0] exp_q[$];
  logic [N-1:0] prev_grant0 = '0;

  mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(HOLD)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant0), .preempted(preempted0),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rw(ch_rw), .mem_en(mem_en0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rw(mem_rw0)
  );

  mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant1), .preempted(preempted1),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rw(ch_rw), .mem_en(mem_en1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rw(mem_rw1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input int lim);
    int n_q, head, pick, own, c;
    bit rel, pre;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        ticket[k][i] = -1;
        mbusy[k][i]  = 1'b0;
      end
      rr[k] = 0; owner[k] = -1; hold[k] = 0; exp_pre[k] = 1'b0;
      if (k == 0) exp_q.delete();
      return;
    end
    n_q = 0; head = -1;
    for (int i = 0; i < N; i++) begin
      if (ticket[k][i] >= 0) begin
        n_q++;
        if (head < 0 || ticket[k][i] < ticket[k][head]) head = i;
      end
    end
    own = owner[k];
    rel = (own >= 0) && !req[own];
    pre = (lim > 0) && (own >= 0) && req[own] && (hold[k] >= lim - 1) && (n_q > 0);
    pick = -1;
    for (int d = 0; d < N; d++) begin
      c = (rr[k] + d) % N;
      if (pick < 0 && req[c] && !mbusy[k][c]) pick = c;
    end
    exp_pre[k] = pre;
    if (own < 0) begin
      if (head >= 0) begin
        owner[k] = head; ticket[k][head] = -1; hold[k] = 0;
        if (k == 0) exp_q.push_back(N'(1 << head));
      end
    end else if (rel) begin
      mbusy[k][own] = 1'b0; owner[k] = -1;
    end else if (pre) begin
      ticket[k][own] = seq[k]; seq[k]++; owner[k] = -1;
    end else if (hold[k] < lim) begin
      hold[k]++;
    end
    if (pick >= 0 && !pre) begin
      ticket[k][pick] = seq[k]; seq[k]++;
      mbusy[k][pick] = 1'b1;
      rr[k] = (pick + 1) % N;
    end
  endtask

  function automatic logic [N-1:0] exp_grant(input int k);
    return (owner[k] >= 0) ? N'(1 << owner[k]) : '0;
  endfunction
  function automatic logic [AW-1:0] exp_addr(input int k);
    return (owner[k] >= 0) ? ch_addr[owner[k]*AW +: AW] : '0;
  endfunction
  function automatic logic [DW-1:0] exp_wdata(input int k);
    return (owner[k] >= 0) ? ch_wdata[owner[k]*DW +: DW] : '0;
  endfunction
  function automatic logic exp_rw(input int k);
    return (owner[k] >= 0) ? ch_rw[owner[k]] : 1'b0;
  endfunction

  task automatic check_outputs();
    check_val("grant0", grant0, exp_grant(0));
    check_val("preempted0", preempted0, exp_pre[0]);
    check_val("mem_en0", mem_en0, owner[0] >= 0);
    check_val("mem_addr0", mem_addr0, exp_addr(0));
    check_val("mem_wdata0", mem_wdata0, exp_wdata(0));
    check_val("mem_rw0", mem_rw0, exp_rw(0));
    check_val("grant1", grant1, exp_grant(1));
    check_val("preempted1", preempted1, exp_pre[1]);
    check_val("mem_en1", mem_en1, owner[1] >= 0);
    check_val("mem_addr1", mem_addr1, exp_addr(1));
    check_val("mem_wdata1", mem_wdata1, exp_wdata(1));
    check_val("mem_rw1", mem_rw1, exp_rw(1));
    if (prev_grant0 == '0 && grant0 != '0) begin
      if (exp_q.size() > 0) check_val("grant_order", grant0, exp_q.pop_front());
      else check_val("grant_order", grant0, '0);
    end
    prev_grant0 = grant0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, HOLD);
    model_step(1, 0);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int own_cnt, pulses, n_seen, last_t, gap_bad;
    logic [N-1:0] seen [N];
    logic [N-1:0] prev;
    seq[0] = 0; seq[1] = 0;
    rst_n    = 1'b0;
    req      = '0;
    ch_addr  = 24'hC3_5A_17;
    ch_wdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    ch_rw    = 3'b010;
    tick();
    tick();
    check_val("reset_grant", grant0, '0);
    check_val("reset_addr", mem_addr0, '0);
    rst_n = 1'b1;

    // Single requester: two-cycle latency, address mux, release.
    req = 3'b010;
    tick();
    check_val("single_lat1", grant0, '0);
    tick();
    check_val("single_lat2", grant0, 3'b010);
    check_val("single_addr", mem_addr0, 8'h5A);
    check_val("single_rw", mem_rw0, 1'b1);
    req = 3'b000;
    tick();
    check_val("single_release", grant0, '0);
    tick();

    // Simultaneous arrivals, twice, to show the rotation returns to channel 0.
    for (int rep = 0; rep < 2; rep++) begin
      if (rep == 0) do_reset();
      req = 3'b111; n_seen = 0; prev = '0; last_t = 0; gap_bad = 0;
      for (int t = 0; t < 30 && n_seen < N; t++) begin
        tick();
        if (prev == '0 && grant0 != '0) begin
          seen[n_seen] = grant0;
          if (n_seen > 0 && t - last_t != 2) gap_bad++;
          last_t = t;
          n_seen++;
          req = req & ~grant0;
        end
        prev = grant0;
      end
      check_val("sim_count", n_seen, N);
      check_val("sim_order0", seen[0], 3'b001);
      check_val("sim_order1", seen[1], 3'b010);
      check_val("sim_order2", seen[2], 3'b100);
      check_val("sim_gap", gap_bad, 0);
      tick(); tick();
    end

    // Arrival during hold, then handover on release.
    do_reset();
    req = 3'b001;
    tick(); tick();
    req = 3'b101;
    tick(); tick();
    req = 3'b100;
    tick();
    check_val("hold_handover_idle", grant0, '0);
    tick();
    check_val("hold_handover_grant", grant0, 3'b100);
    req = 3'b000;
    tick();

    // Preemption after exactly HOLD grant cycles, then re-queued owner regains.
    do_reset();
    req = 3'b001;
    tick(); tick();
    own_cnt = (grant0 == 3'b001) ? 1 : 0;
    pulses  = 0;
    req = 3'b011;
    for (int t = 0; t < 20 && grant0 != 3'b010; t++) begin
      tick();
      if (grant0 == 3'b001) own_cnt++;
      if (preempted0) pulses++;
    end
    check_val("preempt_hold_cycles", own_cnt, HOLD);
    check_val("preempt_pulses", pulses, 1);
    check_val("preempt_next_owner", grant0, 3'b010);
    req = 3'b001;
    tick();
    check_val("preempt_gap", grant0, '0);
    tick();
    check_val("preempt_regain", grant0, 3'b001);

    // Release on the expiry edge wins over preemption.
    do_reset();
    req = 3'b001;
    tick(); tick();
    req = 3'b011;
    tick(); tick(); tick();
    req = 3'b010;
    tick();
    check_val("expiry_release_pulse", preempted0, 1'b0);
    check_val("expiry_release_grant", grant0, '0);
    tick();
    check_val("expiry_next_owner", grant0, 3'b010);

    // Disabled hold limit keeps the owner for 100 cycles.
    do_reset();
    req = 3'b001;
    tick(); tick();
    req = 3'b011;
    pulses = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (preempted1) pulses++;
    end
    check_val("nolimit_pulses", pulses, 0);
    check_val("nolimit_owner", grant1, 3'b001);

    // Reset mid-transfer.
    do_reset();
    req = 3'b010;
    tick(); tick();
    check_val("midrst_before", grant0, 3'b010);
    rst_n = 1'b0;
    tick();
    check_val("midrst_grant", grant0, '0);
    check_val("midrst_en", mem_en0, 1'b0);
    check_val("midrst_wdata", mem_wdata0, '0);
    rst_n = 1'b1;
    req = 3'b001;
    tick();
    check_val("midrst_lat1", grant0, '0);
    tick();
    check_val("midrst_lat2", grant0, 3'b001);

    // Random traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
      end
      ch_addr  = 24'($urandom);
      ch_wdata = {$urandom, $urandom, $urandom};
      ch_rw    = 3'($urandom);
      rst_n    = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel arbiter and bus mux for the shared memory block. Channels request with a level `req` bit and are granted in first-come order through an internal index FIFO. New arrivals on the same cycle are queued in rotating order. An optional hold limit preempts a long-running owner when others are waiting. The block sits between up to `NUM_CH` client modules and the single memory port, replacing the fixed 3-channel controller.

## Interface
Parameters:
- `NUM_CH`, 3: number of requesting channels, range 2–16.
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 32: write-data width.
- `MAX_HOLD`, 16: maximum number of grant cycles before preemption. 0 disables preemption.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in `NUM_CH`: level request per channel. Bit i is channel i.
- `grant` out `NUM_CH`: one-hot, or zero, current owner.
- `preempted` out 1: one-cycle pulse when the owner is revoked by the hold limit.
- `ch_addr` in `NUM_CH*ADDR_W`: flattened per-channel addresses. Channel i uses bits [i*ADDR_W +: ADDR_W].
- `ch_wdata` in `NUM_CH*DATA_W`: flattened per-channel write data.
- `ch_rw` in `NUM_CH`: per-channel read/write flag.
- `mem_en` out 1: `|grant`.
- `mem_addr` out `ADDR_W`: muxed address.
- `mem_wdata` out `DATA_W`: muxed write data.
- `mem_rw` out 1: muxed read/write flag.

## Operation
- State:
  - Index FIFO of depth `NUM_CH`, entries `CH_W = $clog2(NUM_CH)` bits, with an occupancy count.
  - `busy` vector: one bit per channel, set while the channel is queued or granted.
  - Rotating pointer `rr_ptr`.
  - Hold counter `hold_cnt`, saturating at `MAX_HOLD`.
- Arrival candidates are `req & ~busy`. At most one channel is enqueued per cycle:
  - The first candidate at or after `rr_ptr`, wrapping, is pushed.
  - Its `busy` bit is set.
  - `rr_ptr` becomes (index+1) mod `NUM_CH`.
- Grant, when `grant == 0` and the FIFO is non-empty:
  - Pop the head.
  - `grant` becomes the one-hot of the popped index.
  - `hold_cnt` becomes 0.
- Release, when the owner's `req` bit is 0:
  - `grant` becomes 0.
  - The owner's `busy` bit is cleared.
- Preemption applies when `MAX_HOLD` > 0, `hold_cnt == MAX_HOLD-1`, the FIFO is non-empty, and the owner still requests. On that edge:
  - `grant` becomes 0.
  - The owner is pushed at the FIFO tail and its `busy` bit stays set.
  - `preempted` becomes 1.
- If the FIFO is empty at expiry, the owner keeps the grant. Preemption then fires on the first edge at which the FIFO is non-empty.
- Simultaneous events:
  - Arrival and release on the same edge: both take effect.
  - Arrival and preemption on the same edge: the arrival is deferred one cycle, so only one FIFO push happens per edge.
  - Release and expiry on the same edge: release wins. No re-push, no `preempted` pulse.
  - Push with pop on the same edge: legal. The occupancy count is unchanged.
- FIFO overflow is impossible because each channel holds at most one entry. An assertion checks that the FIFO is never pushed when full.
- Mux: `mem_addr`, `mem_wdata` and `mem_rw` take the selected channel's fields. All are 0 when `grant == 0`. This logic is combinational from `grant`.

## Timing
- Reset, on an edge with `rst_n`=0:
  - `grant`=0, `preempted`=0, `mem_en`=0, `mem_addr`=0, `mem_wdata`=0, `mem_rw`=0.
  - FIFO empty, `busy`=0, `rr_ptr`=0, `hold_cnt`=0.
  - Mid-transfer reset drops the grant immediately. No state survives.
- Request latency from idle:
  - `req` high before edge E0: enqueued at E0.
  - `grant` asserted after E1. This is 2 cycles.
- Handover: the owner drops `req` before edge R.
  - `grant`=0 after R.
  - The next owner is granted after R+1. There is exactly one idle cycle between owners.
- Preemption: with the grant asserted after edge G, revocation occurs at edge G+`MAX_HOLD`. The next owner is granted at G+`MAX_HOLD`+1.
- `preempted` is high only for the cycle after the revoking edge.

## Structure
- Package `mem_arb_pkg` holds:
  - Default width constants.
  - A function to convert an index to one-hot.
  - A rotating-priority first-set finder function.
- Sub-module `arb_index_fifo` holds parameters `DEPTH` and `W`, and ports push, pop, din, dout, empty, full and count. It wraps pointers modulo `DEPTH`, which need not be a power of 2.
- `mem_arbiter` contains the arrival/grant/hold logic and the output mux.

## Test plan
Scenarios use `NUM_CH`=3 and `MAX_HOLD`=4 unless stated.
- Reset mid-transfer: grant to channel 1, then hold `rst_n` low for 1 cycle -> all outputs 0 on the next cycle, and a new `req`=3'b001 is granted 2 cycles after release of reset.
- Single requester: `req`=3'b010 at cycle 0 -> `grant`=3'b010 at cycle 2; `mem_addr` follows `ch_addr[15:8]`; drop `req` -> `grant`=0 next cycle.
- Simultaneous arrival: `req`=3'b111 from idle with `rr_ptr`=0 -> grant order ch0, ch1, ch2 with one idle cycle between owners. After ch2 is enqueued, `rr_ptr`=0 again.
- Arrival during hold: ch0 owns, ch2 requests -> ch2 is queued; on ch0 release, ch2 is granted 1 cycle later.
- Preemption: ch0 holds `req` continuously and ch1 requests -> `grant`=3'b001 for exactly 4 cycles, `preempted` pulses once, ch1 is granted next, and ch0 is re-queued and regains the grant after ch1 releases.
- Release at expiry, plus disabled limit: ch0 drops `req` on its 4th grant cycle -> no `preempted` pulse. With `MAX_HOLD`=0, ch0 holds 100 cycles while ch1 waits -> no preemption.
